poly_tile_scheduler: RTL and testbench
======================================

POLY_TILE_SCHEDULER -- requirements
Module: poly_tile_scheduler

Interface
REQ-001 Parameters SHALL be: BIT_WIDTH, default 64, coefficient width; DEGREE_N, default 512, coefficients per polynomial; TILE_N, default 8, coefficients per tile; NUM_POLY, default 4, polynomials in the source buffer.
REQ-002 Derived widths SHALL be: T = DEGREE_N/TILE_N tiles; TW = $clog2(T); SW = $clog2(NUM_POLY); AW = SW+TW.
REQ-003 Ports SHALL be, one per line:
 clk  in  1  clock, all state on rising edge
 rst  in  1  asynchronous, active-high reset
 job_valid_i  in  1  request to multiply polynomial pair
 job_ready_o  out  1  scheduler idle, job accepted when valid&ready
 job_a_sel_i  in  SW  buffer index of operand A
 job_b_sel_i  in  SW  buffer index of operand B
 busy_o  out  1  job in progress
 job_done_o  out  1  one-cycle pulse, job complete
 rd_en_o  out  1  source buffer read strobe
 rd_a_addr_o  out  AW  {a_sel, tile_i}
 rd_b_addr_o  out  AW  {b_sel, tile_j}
 rd_a_data_i  in  TILE_N*BIT_WIDTH  A tile, valid 1 cycle after rd_en_o
 rd_b_data_i  in  TILE_N*BIT_WIDTH  B tile, valid 1 cycle after rd_en_o
 as_o  out  TILE_N*BIT_WIDTH  A tile to poly_mul_wrapper
 bs_o  out  TILE_N*BIT_WIDTH  B tile to poly_mul_wrapper
 start_o  out  1  one-cycle tile-multiply start
 mul_ready_i  in  1  poly_mul_wrapper ready_o
 mul_done_i  in  1  poly_mul_wrapper done
 rst_poly_mul_o  out  1  active-low one-cycle clear of poly_mul_wrapper

Function
REQ-004 FSM states SHALL be IDLE, FETCH, LOAD, WAIT_RDY, ISSUE, WAIT_DONE, CLEAR.
REQ-005 IDLE: job_ready_o=1; on job_valid_i latch a_sel, b_sel, set tile_i=tile_j=0, first=1, go FETCH.
REQ-006 FETCH: rd_en_o=1 with addresses {a_sel,tile_i}, {b_sel,tile_j}; go LOAD.
REQ-007 LOAD: register rd_a_data_i into as_o, rd_b_data_i into bs_o; go ISSUE if first=1, else WAIT_RDY.
REQ-008 WAIT_RDY: hold as_o/bs_o; go ISSUE in the cycle after mul_ready_i is sampled 1.
REQ-009 ISSUE: start_o=1 for exactly one cycle, first cleared; if (tile_i,tile_j)=(T-1,T-1) go WAIT_DONE, else advance indices and go FETCH.
REQ-010 Index order SHALL be tile_i outer, tile_j inner: tile_j increments; at T-1 wraps to 0 and tile_i increments; exactly T*T starts per job.
REQ-011 as_o/bs_o SHALL be stable from one cycle before start_o through the start_o cycle.
REQ-012 Minimum start spacing SHALL be 4 cycles (ISSUE, FETCH, LOAD, WAIT_RDY); mul_ready_i is never sampled earlier than 3 cycles after a start.
REQ-013 First start of a job SHALL occur 3 cycles after the accept cycle, independent of mul_ready_i.
REQ-014 WAIT_DONE: go CLEAR when mul_done_i=1; mul_done_i in any other state SHALL be ignored.
REQ-015 CLEAR: rst_poly_mul_o=0 and job_done_o=1 for that one cycle; go IDLE.
REQ-016 busy_o SHALL be 1 in every state except IDLE; job_valid_i while busy SHALL not be accepted and SHALL not alter latched selects.
REQ-017 mul_ready_i deasserted indefinitely in WAIT_RDY SHALL stall without timeout, without start_o, and with as_o/bs_o unchanged.

Reset
REQ-018 rst=1 SHALL immediately, asynchronously force IDLE, tile_i=tile_j=0, as_o=bs_o=0, start_o=0, rd_en_o=0, job_done_o=0, busy_o=0, rst_poly_mul_o=1, job_ready_o=1.
REQ-019 Reset mid-job SHALL abandon the job with no further start_o, rst_poly_mul_o, or job_done_o; the next accepted job SHALL begin at pair (0,0).

Verification (DEGREE_N=16, TILE_N=4, T=4; buffer model returns tile data = all coefficients {sel,tile})
REQ-020 Assert rst mid-cycle -> outputs take REQ-018 values before the next clk edge.
REQ-021 Job a_sel=1, b_sel=3, mul_ready_i=1, mul_done_i 5 cycles after 16th start -> 16 starts every 4 cycles, order (0,0),(0,1)..(3,3), rd addresses {1,i},{3,j}, one rst_poly_mul_o low cycle plus job_done_o one cycle after done.
REQ-022 Hold mul_ready_i=0 for 10 cycles before 3rd start -> start delayed by exactly 10 cycles, as_o/bs_o constant, total starts still 16.
REQ-023 Pulse mul_done_i during 6th start and job_valid_i during WAIT_RDY -> both ignored, job_ready_o=0, job completes normally.
REQ-024 Assert rst after 5th start, then new job a_sel=2,b_sel=0 -> no stale starts; first new start 3 cycles after accept with rd addresses {2,0},{0,0}.
REQ-025 Scoreboard every start -> as_o={a_sel,tile_i} pattern, bs_o={b_sel,tile_j} pattern for all 16 pairs.

Source files
------------

// File: rtl/poly_tile_scheduler.sv
// rtl/poly_tile_scheduler.sv - walks all tile pairs of two buffered polynomials and issues tile multiplies
module poly_tile_scheduler #(
  parameter int BIT_WIDTH = 64,
  parameter int DEGREE_N  = 512,
  parameter int TILE_N    = 8,
  parameter int NUM_POLY  = 4,
  localparam int T  = DEGREE_N / TILE_N,
  localparam int TW = $clog2(T),
  localparam int SW = $clog2(NUM_POLY),
  localparam int AW = SW + TW,
  localparam int DW = TILE_N * BIT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_valid_i,
  output logic          job_ready_o,
  input  logic [SW-1:0] job_a_sel_i,
  input  logic [SW-1:0] job_b_sel_i,
  output logic          busy_o,
  output logic          job_done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_a_addr_o,
  output logic [AW-1:0] rd_b_addr_o,
  input  logic [DW-1:0] rd_a_data_i,
  input  logic [DW-1:0] rd_b_data_i,
  output logic [DW-1:0] as_o,
  output logic [DW-1:0] bs_o,
  output logic          start_o,
  input  logic          mul_ready_i,
  input  logic          mul_done_i,
  output logic          rst_poly_mul_o
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WAIT_RDY, ISSUE, WAIT_DONE, CLEAR
  } state_t;

  localparam logic [TW-1:0] LAST = TW'(T - 1);

  state_t        state;
  logic [SW-1:0] a_sel;
  logic [SW-1:0] b_sel;
  logic [TW-1:0] tile_i;
  logic [TW-1:0] tile_j;
  logic          first;

  assign rd_a_addr_o = {a_sel, tile_i};
  assign rd_b_addr_o = {b_sel, tile_j};

  // Outputs are registered: each is set on the edge that enters the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      a_sel          <= '0;
      b_sel          <= '0;
      tile_i         <= '0;
      tile_j         <= '0;
      first          <= 1'b0;
      as_o           <= '0;
      bs_o           <= '0;
      start_o        <= 1'b0;
      rd_en_o        <= 1'b0;
      job_done_o     <= 1'b0;
      busy_o         <= 1'b0;
      job_ready_o    <= 1'b1;
      rst_poly_mul_o <= 1'b1;
    end else begin
      start_o        <= 1'b0;
      rd_en_o        <= 1'b0;
      job_done_o     <= 1'b0;
      rst_poly_mul_o <= 1'b1;
      case (state)
        IDLE: begin
          if (job_valid_i) begin
            a_sel       <= job_a_sel_i;
            b_sel       <= job_b_sel_i;
            tile_i      <= '0;
            tile_j      <= '0;
            first       <= 1'b1;
            rd_en_o     <= 1'b1;
            busy_o      <= 1'b1;
            job_ready_o <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          as_o <= rd_a_data_i;
          bs_o <= rd_b_data_i;
          // The first pair needs no ready handshake: the multiplier was just cleared.
          if (first) begin
            start_o <= 1'b1;
            state   <= ISSUE;
          end else begin
            state <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (mul_ready_i) begin
            start_o <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          first <= 1'b0;
          if (tile_i == LAST && tile_j == LAST) begin
            state <= WAIT_DONE;
          end else begin
            if (tile_j == LAST) begin
              tile_j <= '0;
              tile_i <= tile_i + TW'(1);
            end else begin
              tile_j <= tile_j + TW'(1);
            end
            rd_en_o <= 1'b1;
            state   <= FETCH;
          end
        end
        WAIT_DONE: begin
          if (mul_done_i) begin
            rst_poly_mul_o <= 1'b0;
            job_done_o     <= 1'b1;
            state          <= CLEAR;
          end
        end
        CLEAR: begin
          busy_o      <= 1'b0;
          job_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_tile_scheduler.sv
// tb/tb_poly_tile_scheduler.sv - scoreboard bench for poly_tile_scheduler
module tb_poly_tile_scheduler;
  localparam int BW = 16;
  localparam int DW = 4 * BW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready_o;
  logic [1:0]    job_a_sel = '0;
  logic [1:0]    job_b_sel = '0;
  logic          busy_o;
  logic          job_done_o;
  logic          rd_en_o;
  logic [3:0]    rd_a_addr_o;
  logic [3:0]    rd_b_addr_o;
  logic [DW-1:0] rd_a_data = '0;
  logic [DW-1:0] rd_b_data = '0;
  logic [DW-1:0] as_o;
  logic [DW-1:0] bs_o;
  logic          start_o;
  logic          mul_ready = 1'b1;
  logic          mul_done = 1'b0;
  logic          rst_poly_mul_o;

  poly_tile_scheduler #(.BIT_WIDTH(BW), .DEGREE_N(16), .TILE_N(4), .NUM_POLY(4)) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready_o),
    .job_a_sel_i(job_a_sel), .job_b_sel_i(job_b_sel),
    .busy_o(busy_o), .job_done_o(job_done_o),
    .rd_en_o(rd_en_o), .rd_a_addr_o(rd_a_addr_o), .rd_b_addr_o(rd_b_addr_o),
    .rd_a_data_i(rd_a_data), .rd_b_data_i(rd_b_data),
    .as_o(as_o), .bs_o(bs_o), .start_o(start_o),
    .mul_ready_i(mul_ready), .mul_done_i(mul_done),
    .rst_poly_mul_o(rst_poly_mul_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ea;
    logic [3:0] eb;
    int         gap;
  } exp_t;

  exp_t rd_q[$];
  exp_t st_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_starts = 0;
  int   cyc = 0;
  int   last_evt = 0;

  function automatic logic [DW-1:0] pat(input logic [3:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < 4; k++) r[k*BW +: BW] = BW'(a);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: every coefficient of a tile equals its {sel,tile} address.
  always @(posedge clk) begin
    if (rd_en_o) begin
      rd_a_data <= pat(rd_a_addr_o);
      rd_b_data <= pat(rd_b_addr_o);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (job_valid && job_ready_o) last_evt = cyc;
      if (rd_en_o) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 64'(rd_en_o), 64'd0);
        else begin
          mon_e = rd_q.pop_front();
          chk("rd_a_addr", 64'(rd_a_addr_o), 64'(mon_e.ea));
          chk("rd_b_addr", 64'(rd_b_addr_o), 64'(mon_e.eb));
        end
      end
      if (start_o) begin
        n_starts++;
        if (st_q.size() == 0) chk("start_unexpected", 64'(start_o), 64'd0);
        else begin
          mon_e = st_q.pop_front();
          chk("start_as", as_o, pat(mon_e.ea));
          chk("start_bs", bs_o, pat(mon_e.eb));
          chk("start_gap", 64'(cyc - last_evt), 64'(mon_e.gap));
        end
        last_evt = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_job(input logic [1:0] a, input logic [1:0] b, input int stall_idx);
    exp_t e;
    n_starts = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        e.ea  = {a, 2'(i)};
        e.eb  = {b, 2'(j)};
        e.gap = (i == 0 && j == 0) ? 3 : ((i * 4 + j == stall_idx) ? 14 : 4);
        rd_q.push_back(e);
        st_q.push_back(e);
      end
    end
    job_valid = 1'b1;
    job_a_sel = a;
    job_b_sel = b;
    tick();
    job_valid = 1'b0;
    chk("accept_busy", 64'(busy_o), 64'd1);
    chk("accept_ready", 64'(job_ready_o), 64'd0);
  endtask

  task automatic wait_starts(input int target);
    for (int k = 0; k < 300 && n_starts < target; k++) tick();
    if (n_starts < target) chk("wait_starts_timeout", 64'(n_starts), 64'(target));
  endtask

  task automatic finish_job();
    repeat (4) tick();
    chk("wait_done_no_done", 64'(job_done_o), 64'd0);
    chk("wait_done_busy", 64'(busy_o), 64'd1);
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    chk("clear_done", 64'(job_done_o), 64'd1);
    chk("clear_rst_pm", 64'(rst_poly_mul_o), 64'd0);
    tick();
    chk("idle_done", 64'(job_done_o), 64'd0);
    chk("idle_rst_pm", 64'(rst_poly_mul_o), 64'd1);
    chk("idle_ready", 64'(job_ready_o), 64'd1);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("job_starts", 64'(n_starts), 64'd16);
    chk("job_queue_left", 64'(st_q.size() + rd_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, 64'(start_o), 64'd0);
    chk({tag, "_rd_en"}, 64'(rd_en_o), 64'd0);
    chk({tag, "_done"}, 64'(job_done_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_rst_pm"}, 64'(rst_poly_mul_o), 64'd1);
    chk({tag, "_ready"}, 64'(job_ready_o), 64'd1);
    chk({tag, "_as"}, as_o, 64'd0);
    chk({tag, "_bs"}, bs_o, 64'd0);
    chk({tag, "_tile_i"}, 64'(rd_a_addr_o[1:0]), 64'd0);
    chk({tag, "_tile_j"}, 64'(rd_b_addr_o[1:0]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1 chk_reset_outputs("por");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Plain job, ready always high
    issue_job(2'd1, 2'd3, -1);
    wait_starts(16);
    finish_job();

    // Ready withheld for 10 cycles ahead of the third start
    issue_job(2'd3, 2'd1, 2);
    wait_starts(2);
    tick();
    tick();
    mul_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("stall_as", as_o, pat(4'b1100));
      chk("stall_bs", bs_o, pat(4'b0110));
      chk("stall_start", 64'(start_o), 64'd0);
      tick();
    end
    mul_ready = 1'b1;
    wait_starts(16);
    finish_job();

    // Stray done during the 6th start, new request while busy
    issue_job(2'd0, 2'd2, -1);
    wait_starts(5);
    repeat (3) tick();
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    chk("sixth_start_seen", 64'(n_starts), 64'd6);
    job_valid = 1'b1;
    job_a_sel = 2'd3;
    job_b_sel = 2'd3;
    for (int k = 0; k < 3; k++) begin
      chk("busy_ready_low", 64'(job_ready_o), 64'd0);
      chk("busy_no_done", 64'(job_done_o), 64'd0);
      tick();
    end
    job_valid = 1'b0;
    wait_starts(16);
    finish_job();

    // Reset asserted mid-cycle after the 5th start, then a fresh job
    issue_job(2'd1, 2'd1, -1);
    wait_starts(5);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    rd_q.delete();
    st_q.delete();
    n_starts = 0;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("post_reset_starts", 64'(n_starts), 64'd0);
    issue_job(2'd2, 2'd0, -1);
    wait_starts(16);
    finish_job();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
